// File: rtl/video_out_pipe.sv
// video_out_pipe: parametrised VGA timing generator with a latency-matched output stage.
// Coordinates go out to a pixel source; the returned colour is sampled PIPE_LAT clocks
// later, blanked outside the active area and registered onto the pins together with
// sync and data enable delayed by the same amount.
module video_out_pipe #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 4,
   parameter int COORD_W  = 10,
   parameter int PIPE_LAT = 1
) (
   input  logic               clk_pix,
   input  logic               resetn,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_valid,
   output logic               frame_start,
   output logic               line_start,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               vga_hsync,
   output logic               vga_vsync,
   output logic               vga_de
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEGIN = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEGIN = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

   logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
   logic [COORD_W-1:0] v_cnt_q, v_cnt_d;

   // stage0 = {de, hs, vs} for the coordinate currently presented; dly = same, PIPE_LAT clocks old
   logic [2:0] stage0;
   logic [2:0] dly;

   logic [COLOR_W-1:0] vga_r_q, vga_r_d;
   logic [COLOR_W-1:0] vga_g_q, vga_g_d;
   logic [COLOR_W-1:0] vga_b_q, vga_b_d;
   logic               vga_hsync_q, vga_hsync_d;
   logic               vga_vsync_q, vga_vsync_d;
   logic               vga_de_q, vga_de_d;

   // Raster counters: h wraps every line, v advances on the h wrap
   always_comb begin
      h_cnt_d = h_cnt_q + COORD_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + COORD_W'(1);
         end
      end
   end

   // Counter registers; reset parks the raster at (0,0)
   always_ff @(posedge clk_pix) begin
      if (!resetn) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Raster decode; everything facing the source is held quiet while reset is asserted
   always_comb begin
      stage0[2]   = resetn && (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
      stage0[1]   = resetn && (int'(h_cnt_q) >= HS_BEGIN) && (int'(h_cnt_q) < HS_END);
      stage0[0]   = resetn && (int'(v_cnt_q) >= VS_BEGIN) && (int'(v_cnt_q) < VS_END);
      pix_valid   = stage0[2];
      frame_start = resetn && (h_cnt_q == '0) && (v_cnt_q == '0);
      line_start  = resetn && (h_cnt_q == '0);
   end

   assign pix_x = h_cnt_q;
   assign pix_y = v_cnt_q;

   generate
      if (PIPE_LAT == 0) begin : g_direct
         // Combinational source: colour belongs to the coordinate on the bus right now
         assign dly = stage0;
      end else begin : g_delay
         logic [2:0] dl_q [PIPE_LAT];
         logic [2:0] dl_d [PIPE_LAT];

         // Shift the control triple one stage per clock
         always_comb begin
            dl_d[0] = stage0;
            for (int i = 1; i < PIPE_LAT; i++) begin
               dl_d[i] = dl_q[i-1];
            end
         end

         // Delay-line registers; reset flushes every stage to inactive
         always_ff @(posedge clk_pix) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
               if (!resetn) begin
                  dl_q[i] <= '0;
               end else begin
                  dl_q[i] <= dl_d[i];
               end
            end
         end

         assign dly = dl_q[PIPE_LAT-1];
      end
   endgenerate

   // Output stage next values: blank colour unless the delayed DE is set
   always_comb begin
      vga_de_d    = dly[2];
      vga_r_d     = dly[2] ? pix_r : '0;
      vga_g_d     = dly[2] ? pix_g : '0;
      vga_b_d     = dly[2] ? pix_b : '0;
      vga_hsync_d = dly[1] ? HS_POL : ~HS_POL;
      vga_vsync_d = dly[0] ? VS_POL : ~VS_POL;
   end

   // Pin registers
   always_ff @(posedge clk_pix) begin
      if (!resetn) begin
         vga_de_q    <= 1'b0;
         vga_r_q     <= '0;
         vga_g_q     <= '0;
         vga_b_q     <= '0;
         vga_hsync_q <= ~HS_POL;
         vga_vsync_q <= ~VS_POL;
      end else begin
         vga_de_q    <= vga_de_d;
         vga_r_q     <= vga_r_d;
         vga_g_q     <= vga_g_d;
         vga_b_q     <= vga_b_d;
         vga_hsync_q <= vga_hsync_d;
         vga_vsync_q <= vga_vsync_d;
      end
   end

   assign vga_de    = vga_de_q;
   assign vga_r     = vga_r_q;
   assign vga_g     = vga_g_q;
   assign vga_b     = vga_b_q;
   assign vga_hsync = vga_hsync_q;
   assign vga_vsync = vga_vsync_q;

endmodule

// File: tb/tb_video_out_pipe.sv
// Bench for video_out_pipe: three instances (tiny PIPE_LAT=0, mid-size PIPE_LAT=3,
// default 640x480 PIPE_LAT=1) share clock and reset. Expected values come from the raster
// position computed from the number of clocks since reset release.
module tb_video_out_pipe;

   localparam int NI = 3;

   logic clk_pix = 1'b0;
   logic resetn;

   logic [9:0] px [NI];
   logic [9:0] py [NI];
   logic       pv [NI];
   logic       fs [NI];
   logic       ls [NI];
   logic [3:0] sr [NI];
   logic [3:0] sg [NI];
   logic [3:0] sb [NI];
   logic [3:0] vr [NI];
   logic [3:0] vg [NI];
   logic [3:0] vbo [NI];
   logic       hsy [NI];
   logic       vsy [NI];
   logic       de_o [NI];

   int ha [NI], hf [NI], hsw [NI], hbp [NI];
   int va [NI], vf [NI], vsw [NI], vbp [NI];
   int lat [NI];
   bit hp [NI], vp [NI];

   logic [3:0] rt [64];
   logic [3:0] gt [64];
   logic [3:0] bt [64];

   int hs_run [NI], hs_rise [NI], fs_last [NI], pv_rise [NI], de_run [NI], nz_cnt [NI];
   bit pv_prev [NI], de_prev [NI];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk_pix = ~clk_pix;

   video_out_pipe #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(0)
   ) u_tiny (
      .clk_pix(clk_pix), .resetn(resetn),
      .pix_x(px[0]), .pix_y(py[0]), .pix_valid(pv[0]),
      .frame_start(fs[0]), .line_start(ls[0]),
      .pix_r(sr[0]), .pix_g(sg[0]), .pix_b(sb[0]),
      .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vbo[0]),
      .vga_hsync(hsy[0]), .vga_vsync(vsy[0]), .vga_de(de_o[0])
   );

   video_out_pipe #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(3)
   ) u_mid (
      .clk_pix(clk_pix), .resetn(resetn),
      .pix_x(px[1]), .pix_y(py[1]), .pix_valid(pv[1]),
      .frame_start(fs[1]), .line_start(ls[1]),
      .pix_r(sr[1]), .pix_g(sg[1]), .pix_b(sb[1]),
      .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vbo[1]),
      .vga_hsync(hsy[1]), .vga_vsync(vsy[1]), .vga_de(de_o[1])
   );

   video_out_pipe u_dflt (
      .clk_pix(clk_pix), .resetn(resetn),
      .pix_x(px[2]), .pix_y(py[2]), .pix_valid(pv[2]),
      .frame_start(fs[2]), .line_start(ls[2]),
      .pix_r(sr[2]), .pix_g(sg[2]), .pix_b(sb[2]),
      .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vbo[2]),
      .vga_hsync(hsy[2]), .vga_vsync(vsy[2]), .vga_de(de_o[2])
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Colour each instance's source returns for raster position (h,v)
   function automatic logic [11:0] col(input int id, input int h, input int v);
      logic [11:0] c;
      c = {rt[(3*h + v) % 64], gt[(h + 5*v) % 64], bt[(7*h + v) % 64]};
      if (id == 1) begin
         c[11:8] = 4'(h);
      end else if (id == 2) begin
         c = 12'hFFF;
      end
      return c;
   endfunction

   // k = clocks since the last reset edge (= raster index presented now); rst = current resetn
   task automatic check_inst(input int id, input int cyc, input int k, input bit rst);
      string nm;
      int ht, vt, h, v, c, hh, vv;
      bit d, hsa, vsa;
      logic [14:0] ep;
      nm = (id == 0) ? "tiny" : (id == 1) ? "mid" : "dflt";
      ht = ha[id] + hf[id] + hsw[id] + hbp[id];
      vt = va[id] + vf[id] + vsw[id] + vbp[id];
      h  = k % ht;
      v  = (k / ht) % vt;
      check_eq({nm, "_coord"}, {px[id], py[id], fs[id], ls[id]},
               {10'(h), 10'(v), rst && h == 0 && v == 0, rst && h == 0});
      if (rst) check_eq({nm, "_valid"}, pv[id], (h < ha[id]) && (v < va[id]));

      c = k - 1 - lat[id];
      if (c < 0) begin
         ep = {1'b0, ~hp[id], ~vp[id], 12'h000};
      end else begin
         hh  = c % ht;
         vv  = (c / ht) % vt;
         d   = (hh < ha[id]) && (vv < va[id]);
         hsa = (hh >= ha[id] + hf[id]) && (hh < ha[id] + hf[id] + hsw[id]);
         vsa = (vv >= va[id] + vf[id]) && (vv < va[id] + vf[id] + vsw[id]);
         ep  = {d, hsa ? hp[id] : ~hp[id], vsa ? vp[id] : ~vp[id], d ? col(id, hh, vv) : 12'h000};
      end
      check_eq({nm, "_pins"}, {de_o[id], hsy[id], vsy[id], vr[id], vg[id], vbo[id]}, ep);

      // Pulse widths, periods and DE latency measured on the pins
      if (k == 0) begin
         hs_run[id]  = 0;
         hs_rise[id] = -1;
         de_run[id]  = 0;
         nz_cnt[id]  = 0;
         de_prev[id] = 1'b0;
      end else begin
         if (hsy[id] == hp[id]) begin
            if (hs_run[id] == 0) begin
               if (hs_rise[id] >= 0) check_eq({nm, "_hs_period"}, cyc - hs_rise[id], ht);
               hs_rise[id] = cyc;
            end
            hs_run[id]++;
         end else if (hs_run[id] > 0) begin
            check_eq({nm, "_hs_width"}, hs_run[id], hsw[id]);
            hs_run[id] = 0;
         end
         if (de_o[id] && !de_prev[id] && pv_rise[id] >= 0)
            check_eq({nm, "_de_latency"}, cyc - pv_rise[id], lat[id] + 1);
         if (de_o[id]) begin
            de_run[id]++;
            if ({vr[id], vg[id], vbo[id]} != 12'h000) nz_cnt[id]++;
         end else if (de_run[id] > 0) begin
            check_eq({nm, "_de_len"}, de_run[id], ha[id]);
            if (id == 2) check_eq({nm, "_nonzero"}, nz_cnt[id], ha[id]);
            de_run[id] = 0;
            nz_cnt[id] = 0;
         end
         de_prev[id] = de_o[id];
      end

      if (!rst) begin
         pv_rise[id] = -1;
         pv_prev[id] = 1'b0;
         fs_last[id] = -1;
      end else begin
         if (pv[id] && !pv_prev[id]) pv_rise[id] = cyc;
         pv_prev[id] = pv[id];
         if (fs[id]) begin
            if (fs_last[id] >= 0) check_eq({nm, "_frame_period"}, cyc - fs_last[id], ht * vt);
            fs_last[id] = cyc;
         end
      end
   endtask

   initial begin
      int k, hold, rnd2;
      bit did_mid, did_2;
      logic [11:0] bpipe [3];

      ha  = '{4, 20, 640};  hf  = '{1, 3, 16};  hsw = '{2, 5, 96};  hbp = '{1, 4, 48};
      va  = '{3, 6, 480};   vf  = '{1, 2, 10};  vsw = '{1, 2, 2};   vbp = '{1, 3, 33};
      lat = '{0, 3, 1};     hp  = '{1'b1, 1'b0, 1'b0};  vp = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 64; i++) begin
         rt[i] = 4'($urandom);
         gt[i] = 4'($urandom);
         bt[i] = 4'($urandom);
      end
      for (int i = 0; i < 3; i++) bpipe[i] = 12'h000;
      for (int i = 0; i < NI; i++) begin
         sr[i] = 4'h0;
         sg[i] = 4'h0;
         sb[i] = 4'h0;
      end
      rnd2    = $urandom_range(500, 2500);
      did_mid = 1'b0;
      did_2   = 1'b0;
      resetn  = 1'b0;
      hold    = 4;
      k       = 0;

      for (int cyc = 0; cyc < 8000; cyc++) begin
         @(posedge clk_pix);
         #1;
         // The edge just taken either reset the raster or advanced it
         k = resetn ? k + 1 : 0;
         if (cyc == 0) k = 0;
         if (hold > 0) begin
            resetn = 1'b0;
            hold--;
         end else if (resetn && !did_mid && k == 3018) begin
            // mid-size instance sits at (10,3), default instance outside its sync pulse
            did_mid = 1'b1;
            resetn  = 1'b0;
            hold    = $urandom_range(0, 5);
         end else if (resetn && did_mid && !did_2 && k == rnd2) begin
            did_2  = 1'b1;
            resetn = 1'b0;
            hold   = $urandom_range(0, 5);
         end else begin
            resetn = 1'b1;
         end
         {sr[0], sg[0], sb[0]} = col(0, int'(px[0]), int'(py[0]));
         {sr[1], sg[1], sb[1]} = bpipe[2];
         bpipe[2] = bpipe[1];
         bpipe[1] = bpipe[0];
         bpipe[0] = col(1, int'(px[1]), int'(py[1]));
         {sr[2], sg[2], sb[2]} = 12'hFFF;
         @(negedge clk_pix);
         for (int id = 0; id < NI; id++) check_inst(id, cyc, k, resetn);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
